fuzz_vector_harness: RTL and testbench

Self-checking stimulus/response stage that sits in front of and behind a flattened fuzz wrapper. It drives the wrapper's `in_flat` port with pseudo-random vectors from a 32-bit LFSR and holds each vector for a programmable settle time. It then samples the wrapper's `out_flat` into a 16-bit MISR signature, so one run of N vectors reduces to a single comparable value. One instance serves any `<module>_wrapper` of up to 32 input bits and 16 output bits.

---
 rtl/fuzz_vector_harness.sv | 104 ++++++++++
 tb/tb_fuzz_vector_harness.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fuzz_vector_harness.sv
// Stimulus/response harness for a flattened fuzz wrapper: LFSR-driven input vectors,
// a programmable settle time, and a 16-bit MISR that compacts the responses of a run.
module fuzz_vector_harness #(
  parameter int unsigned IN_W        = 27,
  parameter int unsigned OUT_W       = 8,
  parameter int unsigned NUM_VECTORS = 256,
  parameter int unsigned SETTLE_CYC  = 1,
  parameter logic [31:0] SEED        = 32'h0000_0001
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  output logic [IN_W-1:0]  in_flat,
  input  logic [OUT_W-1:0] out_flat,
  output logic             busy,
  output logic             done,
  output logic [15:0]      vec_count,
  output logic [15:0]      signature
);

  // An all-zero LFSR would lock up, so a zero seed is promoted to 1.
  localparam logic [31:0] SEED_EFF = (SEED == 32'd0) ? 32'd1 : SEED;
  localparam int unsigned CNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYC - 1);
  localparam logic [15:0] LAST_VEC = 16'(NUM_VECTORS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_APPLY,
    S_SETTLE,
    S_CAPTURE,
    S_DONE
  } state_t;

  state_t           state, state_nxt;
  logic [31:0]      lfsr;
  logic [31:0]      lfsr_nxt;
  logic [15:0]      sig_nxt;
  logic [CNT_W-1:0] settle_cnt;

  assign lfsr_nxt = {1'b0, lfsr[31:1]} ^ (lfsr[0] ? 32'h8020_0003 : 32'h0);
  assign sig_nxt  = {signature[14:0], 1'b0} ^ (signature[15] ? 16'h1021 : 16'h0)
                  ^ 16'(out_flat);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // NOTE: the default is assigned first so no path leaves state_nxt unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE: if (start) state_nxt = S_APPLY;
      S_APPLY:        state_nxt = S_SETTLE;
      S_SETTLE:       if (settle_cnt == '0) state_nxt = S_CAPTURE;
      S_CAPTURE:      state_nxt = (vec_count == LAST_VEC) ? S_DONE : S_APPLY;
      default:        state_nxt = S_IDLE;
    endcase
    if (abort) state_nxt = S_IDLE;
  end

  assign busy = (state == S_APPLY) || (state == S_SETTLE) || (state == S_CAPTURE);
  assign done = (state == S_DONE);

  // Abort freezes the datapath so a partial signature stays readable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_flat    <= '0;
      vec_count  <= '0;
      signature  <= '0;
      lfsr       <= SEED_EFF;
      settle_cnt <= '0;
    end else if (!abort) begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            lfsr      <= SEED_EFF;
            signature <= '0;
            vec_count <= '0;
          end
        end
        S_APPLY: begin
          in_flat    <= lfsr[IN_W-1:0];
          settle_cnt <= SETTLE_LOAD;
        end
        S_SETTLE: begin
          if (settle_cnt != '0) settle_cnt <= settle_cnt - 1'b1;
        end
        S_CAPTURE: begin
          signature <= sig_nxt;
          vec_count <= vec_count + 16'd1;
          lfsr      <= lfsr_nxt;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fuzz_vector_harness.sv
// Bench for fuzz_vector_harness: several parameterisations run side by side, with a
// behavioural wrapper and an independent LFSR/MISR model feeding a scoreboard.
module tb_fuzz_vector_harness;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  // Main instance: defaults, driven by a behavioural wrapper.
  logic        start_m = 1'b0, abort_m = 1'b0;
  logic [26:0] in_m;
  logic [7:0]  out_m;
  logic        busy_m, done_m;
  logic [15:0] vc_m, sig_m;

  // Auxiliary instances share one start/abort pair.
  logic        start_a = 1'b0, abort_a = 1'b0;
  logic [26:0] in_s0, in_f1, in_f2, in_z, in_l3;
  logic        busy_s0, busy_f1, busy_f2, busy_z, busy_l3;
  logic        done_s0, done_f1, done_f2, done_z, done_l3;
  logic [15:0] vc_s0, vc_f1, vc_f2, vc_z, vc_l3;
  logic [15:0] sig_s0, sig_f1, sig_f2, sig_z, sig_l3;
  logic [7:0]  out_s0, out_l3;

  function automatic logic [7:0] wrap(input logic [26:0] v);
    return v[7:0] ^ v[15:8] ^ {v[22:16], v[23]} ^ {5'b0, v[26:24]};
  endfunction

  function automatic logic [31:0] model_lfsr(input logic [31:0] l);
    logic [31:0] r;
    r = l >> 1;
    if (l[0]) r = r ^ 32'h8020_0003;
    return r;
  endfunction

  function automatic logic [15:0] model_sig(input logic [15:0] s, input logic [7:0] o);
    logic [15:0] r;
    r = s << 1;
    if (s[15]) r = r ^ 16'h1021;
    return r ^ {8'h00, o};
  endfunction

  assign out_m  = wrap(in_m);
  assign out_s0 = wrap(in_s0);
  assign out_l3 = wrap(in_l3);

  fuzz_vector_harness #(.IN_W(27), .OUT_W(8), .NUM_VECTORS(256), .SETTLE_CYC(1), .SEED(32'h1))
    u_main (.clk(clk), .rst_n(rst_n), .start(start_m), .abort(abort_m), .in_flat(in_m),
            .out_flat(out_m), .busy(busy_m), .done(done_m), .vec_count(vc_m), .signature(sig_m));

  fuzz_vector_harness #(.IN_W(27), .OUT_W(8), .NUM_VECTORS(4), .SETTLE_CYC(1), .SEED(32'h0))
    u_seed0 (.clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort_a), .in_flat(in_s0),
             .out_flat(out_s0), .busy(busy_s0), .done(done_s0), .vec_count(vc_s0), .signature(sig_s0));

  fuzz_vector_harness #(.IN_W(27), .OUT_W(8), .NUM_VECTORS(1), .SETTLE_CYC(1), .SEED(32'h1))
    u_ff1 (.clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort_a), .in_flat(in_f1),
           .out_flat(8'hFF), .busy(busy_f1), .done(done_f1), .vec_count(vc_f1), .signature(sig_f1));

  fuzz_vector_harness #(.IN_W(27), .OUT_W(8), .NUM_VECTORS(2), .SETTLE_CYC(1), .SEED(32'h1))
    u_ff2 (.clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort_a), .in_flat(in_f2),
           .out_flat(8'hFF), .busy(busy_f2), .done(done_f2), .vec_count(vc_f2), .signature(sig_f2));

  fuzz_vector_harness #(.IN_W(27), .OUT_W(8), .NUM_VECTORS(4), .SETTLE_CYC(1), .SEED(32'h1))
    u_zero (.clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort_a), .in_flat(in_z),
            .out_flat(8'h00), .busy(busy_z), .done(done_z), .vec_count(vc_z), .signature(sig_z));

  fuzz_vector_harness #(.IN_W(27), .OUT_W(8), .NUM_VECTORS(4), .SETTLE_CYC(3), .SEED(32'h1))
    u_lat3 (.clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort_a), .in_flat(in_l3),
            .out_flat(out_l3), .busy(busy_l3), .done(done_l3), .vec_count(vc_l3), .signature(sig_l3));

  typedef struct {
    logic [26:0] vin;
    logic [15:0] sig;
  } exp_t;
  exp_t sb[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected in_flat/signature after each capture of one main run.
  task automatic push_main_run(input int n);
    logic [31:0] l;
    logic [15:0] s;
    exp_t e;
    l = 32'h1;
    s = 16'h0;
    for (int i = 0; i < n; i++) begin
      e.vin = l[26:0];
      s = model_sig(s, wrap(l[26:0]));
      e.sig = s;
      sb.push_back(e);
      l = model_lfsr(l);
    end
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({in_m, sig_m, vc_m, busy_m, done_m} !== '0) begin
      fails++;
      $display("FAIL power_on_reset: got in=%h sig=%h vc=%0d busy=%b done=%b, expected all zero",
               in_m, sig_m, vc_m, busy_m, done_m);
    end
    #12 rst_n = 1'b1;
    tick();
    start_m = 1'b1;
    tick();
    start_m = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    checks++;
    if (vc_m !== 16'd2 || busy_m !== 1'b1) begin
      fails++;
      $display("FAIL pre_reset_progress: got vc=%0d busy=%b, expected vc=2 busy=1", vc_m, busy_m);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({in_m, sig_m, vc_m, busy_m, done_m} !== '0) begin
      fails++;
      $display("FAIL async_reset: got in=%h sig=%h vc=%0d busy=%b done=%b, expected all zero",
               in_m, sig_m, vc_m, busy_m, done_m);
    end
    #1 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    checks++;
    if (busy_m !== 1'b0 || vc_m !== 16'd0) begin
      fails++;
      $display("FAIL no_resume_after_reset: got busy=%b vc=%0d, expected busy=0 vc=0", busy_m, vc_m);
    end
  endtask

  task automatic test_lfsr();
    logic [31:0] l;
    l = 32'h1;
    for (int i = 0; i < 3; i++) l = model_lfsr(l);
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    tick();
    checks++;
    if (in_s0 !== 27'h000_0001) begin
      fails++;
      $display("FAIL lfsr_first_seed0: got %h expected %h", in_s0, 27'h000_0001);
    end
    for (int i = 0; i < 3; i++) tick();
    checks++;
    if (in_s0 !== 27'h020_0003) begin
      fails++;
      $display("FAIL lfsr_second_seed0: got %h expected %h", in_s0, 27'h020_0003);
    end
    for (int i = 0; i < 30 && !done_l3; i++) tick();
    checks++;
    if (in_s0 !== l[26:0]) begin
      fails++;
      $display("FAIL lfsr_fourth_seed0: got %h expected %h", in_s0, l[26:0]);
    end
  endtask

  task automatic test_misr();
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    for (int i = 0; i < 30 && !done_l3; i++) tick();
    checks++;
    if (sig_f1 !== 16'h00FF || vc_f1 !== 16'd1) begin
      fails++;
      $display("FAIL misr_one_vector: got sig=%h vc=%0d expected sig=00ff vc=1", sig_f1, vc_f1);
    end
    checks++;
    if (sig_f2 !== 16'h0101 || vc_f2 !== 16'd2) begin
      fails++;
      $display("FAIL misr_two_vectors: got sig=%h vc=%0d expected sig=0101 vc=2", sig_f2, vc_f2);
    end
    checks++;
    if (sig_z !== 16'h0000 || vc_z !== 16'd4) begin
      fails++;
      $display("FAIL misr_zero_response: got sig=%h vc=%0d expected sig=0000 vc=4", sig_z, vc_z);
    end
  endtask

  task automatic test_latency();
    int first_z, first_l3;
    first_z = -1;
    first_l3 = -1;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    checks++;
    if (busy_z !== 1'b1 || done_z !== 1'b0) begin
      fails++;
      $display("FAIL busy_after_start: got busy=%b done=%b expected busy=1 done=0", busy_z, done_z);
    end
    for (int e = 1; e <= 25; e++) begin
      tick();
      if (done_z && first_z < 0) first_z = e;
      if (done_l3 && first_l3 < 0) first_l3 = e;
    end
    checks++;
    if (first_z != 12) begin
      fails++;
      $display("FAIL latency_settle1: done after %0d edges, expected 12", first_z);
    end
    checks++;
    if (first_l3 != 20) begin
      fails++;
      $display("FAIL latency_settle3: done after %0d edges, expected 20", first_l3);
    end
    checks++;
    if (busy_l3 !== 1'b0 || vc_l3 !== 16'd4) begin
      fails++;
      $display("FAIL done_state_settle3: got busy=%b vc=%0d expected busy=0 vc=4", busy_l3, vc_l3);
    end
  endtask

  task automatic test_abort();
    logic [31:0] l;
    logic [15:0] s;
    l = 32'h1;
    s = 16'h0;
    for (int i = 0; i < 2; i++) begin
      s = model_sig(s, wrap(l[26:0]));
      l = model_lfsr(l);
    end
    start_m = 1'b1;
    tick();
    start_m = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    abort_m = 1'b1;
    tick();
    abort_m = 1'b0;
    checks++;
    if (busy_m !== 1'b0 || done_m !== 1'b0 || vc_m !== 16'd2) begin
      fails++;
      $display("FAIL abort_in_settle: got busy=%b done=%b vc=%0d expected busy=0 done=0 vc=2",
               busy_m, done_m, vc_m);
    end
    checks++;
    if (sig_m !== s || in_m !== l[26:0]) begin
      fails++;
      $display("FAIL abort_holds_partial: got sig=%h in=%h expected sig=%h in=%h",
               sig_m, in_m, s, l[26:0]);
    end
    for (int i = 0; i < 3; i++) tick();
    start_m = 1'b1;
    abort_m = 1'b1;
    tick();
    start_m = 1'b0;
    abort_m = 1'b0;
    tick();
    checks++;
    if (busy_m !== 1'b0 || vc_m !== 16'd2 || sig_m !== s) begin
      fails++;
      $display("FAIL abort_beats_start: got busy=%b vc=%0d sig=%h expected busy=0 vc=2 sig=%h",
               busy_m, vc_m, sig_m, s);
    end
  endtask

  task automatic test_start_while_busy();
    start_m = 1'b1;
    tick();
    for (int i = 0; i < 9; i++) tick();
    start_m = 1'b0;
    checks++;
    if (vc_m !== 16'd3 || busy_m !== 1'b1) begin
      fails++;
      $display("FAIL start_ignored_busy: got vc=%0d busy=%b expected vc=3 busy=1", vc_m, busy_m);
    end
    abort_m = 1'b1;
    tick();
    abort_m = 1'b0;
  endtask

  task automatic run_end_to_end(output logic [15:0] final_sig);
    logic [15:0] prev;
    exp_t e;
    sb.delete();
    push_main_run(256);
    start_m = 1'b1;
    tick();
    start_m = 1'b0;
    prev = vc_m;
    for (int i = 0; i < 800 && !done_m; i++) begin
      tick();
      if (vc_m !== prev) begin
        prev = vc_m;
        checks++;
        if (sb.size() == 0) begin
          fails++;
          $display("FAIL e2e_extra_capture: vc=%0d with scoreboard empty", vc_m);
        end else begin
          e = sb.pop_front();
          if (in_m !== e.vin || sig_m !== e.sig) begin
            fails++;
            $display("FAIL e2e_vector_%0d: got in=%h sig=%h expected in=%h sig=%h",
                     vc_m, in_m, sig_m, e.vin, e.sig);
          end
        end
      end
    end
    checks++;
    if (done_m !== 1'b1 || vc_m !== 16'd256 || sb.size() != 0) begin
      fails++;
      $display("FAIL e2e_completion: got done=%b vc=%0d left=%0d expected done=1 vc=256 left=0",
               done_m, vc_m, sb.size());
    end
    final_sig = sig_m;
  endtask

  task automatic test_back_to_back();
    logic [15:0] sig_a, sig_b;
    run_end_to_end(sig_a);
    tick();
    run_end_to_end(sig_b);
    checks++;
    if (sig_b !== sig_a) begin
      fails++;
      $display("FAIL e2e_repeatable: got %h expected %h", sig_b, sig_a);
    end
  endtask

  initial begin
    test_reset();
    test_lfsr();
    test_misr();
    test_latency();
    test_abort();
    test_start_while_busy();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
